// File: rtl/des_f_function_pipe_if.sv
// Upstream and downstream handshake bundle for the pipelined DES round function.
// The pipe connects through the slave modport; the driving side uses master.
interface des_f_function_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r_in;
    logic [47:0] k_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f_out;
    logic [31:0] s_out;

    modport slave (
        input  in_valid,
        input  r_in,
        input  k_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output f_out,
        output s_out
    );

    modport master (
        output in_valid,
        output r_in,
        output k_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  f_out,
        input  s_out
    );
endinterface

// File: rtl/des_f_function_pipe.sv
// Two-stage DES round function f(R,K): stage 1 registers E(R)^K,
// stage 2 registers the S-box outputs and their P permutation.
module des_f_function_pipe (
    input  logic                  clk,
    input  logic                  rst_n,
    des_f_function_pipe_if.slave  bus
);

    // One 64-bit word per S-box row: nibble 15 (MSBs) is column 0.
    // Word index is {box[2:0], row[1:0]}, box 0 = S1.
    localparam logic [63:0] SBOX_ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
        64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
        64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
        64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
        64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
        64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
        64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
        64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
        64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box,
                                               input logic [5:0] grp);
        logic [63:0] row_word;
        logic [3:0]  col;
        row_word = SBOX_ROWS[{box, grp[5], grp[0]}];
        col      = grp[4:1];
        return row_word[{~col, 2'b00} +: 4];
    endfunction

    logic        s1_valid;
    logic        s2_valid;
    logic [47:0] x1_q;
    logic [31:0] s_q;
    logic [31:0] f_q;

    logic        adv2;
    logic        accept;
    logic        pop;
    logic [47:0] e_r;
    logic [31:0] s_next;
    logic [31:0] f_next;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; ready never depends on valid of the same side, data is held
    // stable by the sender until the transfer, and the pipe never drops or
    // repeats a transfer. Stage 2 moves when it is empty or being popped.
    assign adv2         = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | adv2;
    assign accept       = bus.in_valid & bus.in_ready;
    assign pop          = s2_valid & bus.out_ready;

    // E expansion; DES bit n lives at r_in[32-n].
    assign e_r = {bus.r_in[0],     bus.r_in[31:27],
                  bus.r_in[28:23], bus.r_in[24:19],
                  bus.r_in[20:15], bus.r_in[16:11],
                  bus.r_in[12:7],  bus.r_in[8:3],
                  bus.r_in[4:0],   bus.r_in[31]};

    always_comb begin
        s_next = '0;
        for (int i = 0; i < 8; i++) begin
            s_next[31-4*i -: 4] = sbox_lookup(i[2:0], x1_q[47-6*i -: 6]);
        end
    end

    // P permutation written as f[32-j] = s[32-P(j)] for j = 1..32.
    assign f_next = {s_next[16], s_next[25], s_next[12], s_next[11],
                     s_next[3],  s_next[20], s_next[4],  s_next[15],
                     s_next[31], s_next[17], s_next[9],  s_next[6],
                     s_next[27], s_next[14], s_next[1],  s_next[22],
                     s_next[30], s_next[24], s_next[8],  s_next[18],
                     s_next[0],  s_next[5],  s_next[29], s_next[23],
                     s_next[13], s_next[19], s_next[2],  s_next[26],
                     s_next[10], s_next[21], s_next[28], s_next[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            x1_q     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                x1_q     <= e_r ^ bus.k_in;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s_q      <= '0;
            f_q      <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= 1'b1;
                s_q      <= s_next;
                f_q      <= f_next;
            end else if (pop) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.s_out     = s_q;
    assign bus.f_out     = f_q;

endmodule

// File: tb/tb_des_f_function_pipe.sv
// Randomized self-checking bench for des_f_function_pipe against a
// table-driven DES f-function model and an in-order expected queue.
module tb_des_f_function_pipe;

    // ---------------- reference tables (DES bit numbers, 1-based) --------
    localparam int E_TAB [48] = '{
        32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,   8, 9,10,11,12,13,
        12,13,14,15,16,17,  16,17,18,19,20,21,  20,21,22,23,24,25,
        24,25,26,27,28,29,  28,29,30,31,32, 1};

    localparam int P_TAB [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

    localparam int SBOX [8][4][16] = '{
        '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
          '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
          '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
          '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
        '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
          '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
          '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
          '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
        '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
          '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
          '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
          '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
        '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
          '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
          '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
          '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
        '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
          '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
          '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
          '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
        '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
          '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
          '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
          '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
        '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
          '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
          '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
          '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
        '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
          '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
          '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
          '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}};

    // ---------------- clock / reset / DUT ---------------------------------
    logic clk;
    logic rst_n;

    des_f_function_pipe_if bus();

    des_f_function_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ------------------------------------
    logic [63:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    logic        last_acc;
    logic        obs_ov;
    logic [31:0] obs_f;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // f(R,K) straight from the DES definition; returns {s, f} and E(R)^K.
    function automatic logic [63:0] ref_f(input logic [31:0] r,
                                          input logic [47:0] k,
                                          output logic [47:0] x);
        logic [31:0] s;
        logic [31:0] f;
        logic [5:0]  six;
        int          row;
        int          col;
        for (int j = 1; j <= 48; j++) x[48-j] = r[32-E_TAB[j-1]] ^ k[48-j];
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[31-4*b -: 4] = 4'(SBOX[b][row][col]);
        end
        for (int j = 1; j <= 32; j++) f[32-j] = s[32-P_TAB[j-1]];
        return {s, f};
    endfunction

    // ---------------- driver ----------------------------------------------
    // Called just after a falling edge; drives for the next rising edge and
    // samples outputs 1 ns later, well away from the active edge.
    task automatic step(input logic iv, input logic [31:0] r,
                        input logic [47:0] k, input logic ordy);
        logic [47:0] xx;
        logic [63:0] exp;
        bus.in_valid  = iv;
        bus.r_in      = r;
        bus.k_in      = k;
        bus.out_ready = ordy;
        #1;
        obs_ov = bus.out_valid;
        obs_f  = bus.f_out;
        if (bus.out_valid) begin
            check("out_valid_has_pending", 64'(exp_q.size() != 0), 64'd1);
            if (ordy && exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("s_out", 64'(bus.s_out), 64'(exp[63:32]));
                check("f_out", 64'(bus.f_out), 64'(exp[31:0]));
            end
        end
        last_acc = iv & bus.in_ready;
        if (last_acc) exp_q.push_back(ref_f(r, k, xx));
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            step(1'b0, 32'h0, 48'h0, 1'b1);
            cyc++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        logic [31:0] cur_r;
        logic [47:0] cur_k;
        logic [63:0] rnd;
        logic [31:0] held_f;
        logic        have_vec;
        int          n_acc;
        int          cyc;

        n_cmp = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.r_in      = '0;
        bus.k_in      = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;

        // reset state
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_f_out",     64'(bus.f_out),     64'd0);
        check("rst_s_out",     64'(bus.s_out),     64'd0);
        check("rst_x1",        64'(dut.x1_q),      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // zero vector
        step(1'b1, 32'h0, 48'h0, 1'b1);
        check("zero_accept", 64'(last_acc), 64'd1);
        check("zero_lat1_ov", 64'(bus.out_valid), 64'd0);
        step(1'b0, 32'h0, 48'h0, 1'b1);
        check("zero_ov", 64'(bus.out_valid), 64'd1);
        check("zero_s", 64'(bus.s_out), 64'hEFA72C4D);
        check("zero_f", 64'(bus.f_out), 64'hD8D8DBBC);
        drain(4);

        // FIPS round-1 example
        step(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
        check("fips_x1", 64'(dut.x1_q), 64'h6117BA866527);
        step(1'b0, 32'h0, 48'h0, 1'b1);
        check("fips_ov", 64'(bus.out_valid), 64'd1);
        check("fips_s", 64'(bus.s_out), 64'h5C82B597);
        check("fips_f", 64'(bus.f_out), 64'h234AA9BB);
        drain(4);
        step(1'b0, 32'h0, 48'h0, 1'b1);

        // streaming, out_ready held high
        for (int i = 0; i < 18; i++) begin
            rnd = {$urandom, $urandom};
            step(i < 16, rnd[31:0], rnd[63:16], 1'b1);
            if (i < 16) check("stream_in_ready", 64'(last_acc), 64'd1);
            check("stream_out_valid", 64'(obs_ov), 64'(i >= 2));
        end
        drain(4);
        step(1'b0, 32'h0, 48'h0, 1'b1);

        // backpressure
        n_acc = 0;
        have_vec = 1'b0;
        held_f = '0;
        for (int i = 0; i < 5; i++) begin
            if (!have_vec) begin
                rnd = {$urandom, $urandom};
                cur_r = rnd[31:0];
                cur_k = rnd[63:16];
                have_vec = 1'b1;
            end
            step(1'b1, cur_r, cur_k, 1'b0);
            if (last_acc) begin
                n_acc++;
                have_vec = 1'b0;
            end
            if (i >= 2) check("bp_in_ready_low", 64'(last_acc), 64'd0);
            if (i == 2) held_f = obs_f;
            if (i > 2) check("bp_f_stable", 64'(obs_f), 64'(held_f));
        end
        check("bp_accepted", 64'(n_acc), 64'd2);
        check("bp_pending", 64'(exp_q.size()), 64'd2);
        drain(6);
        step(1'b0, 32'h0, 48'h0, 1'b1);

        // random valid/ready toggling over 1000 vectors
        n_acc = 0;
        cyc = 0;
        have_vec = 1'b0;
        while (n_acc < 1000 && cyc < 20000) begin
            if (!have_vec) begin
                rnd = {$urandom, $urandom};
                cur_r = rnd[31:0];
                cur_k = rnd[63:16];
                have_vec = 1'b1;
            end
            step($urandom_range(0, 3) != 0, cur_r, cur_k,
                 $urandom_range(0, 3) != 0);
            if (last_acc) begin
                n_acc++;
                have_vec = 1'b0;
            end
            cyc++;
        end
        check("rand_all_accepted", 64'(n_acc), 64'd1000);
        drain(20);

        // reset with both stages full
        rnd = {$urandom, $urandom};
        step(1'b1, rnd[31:0], rnd[63:16], 1'b0);
        rnd = {$urandom, $urandom};
        step(1'b1, rnd[31:0], rnd[63:16], 1'b0);
        check("full_before_rst_ov", 64'(bus.out_valid), 64'd1);
        check("full_before_rst_pend", 64'(exp_q.size()), 64'd2);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 48'h0, 1'b1);
            check("post_rst_quiet", 64'(obs_ov), 64'd0);
        end
        rnd = {$urandom, $urandom};
        step(1'b1, rnd[31:0], rnd[63:16], 1'b1);
        check("post_rst_accept", 64'(last_acc), 64'd1);
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
